// File: rtl/md_protocol_monitor.sv
// Multi-channel MD valid/ready protocol monitor: per-channel handshake, stability, err,
// alignment and stall-timeout checks with sticky flags, first-violation capture and counters.
module md_protocol_monitor #(
    parameter int unsigned ALGN_DATA_WIDTH = 32,
    parameter int unsigned BUS_BYTES       = ALGN_DATA_WIDTH / 8,
    parameter int unsigned OFFSET_W        = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1,
    parameter int unsigned SIZE_W          = $clog2(BUS_BYTES) + 1,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned TIMEOUT_W       = 8,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_CH-1:0]                   md_valid,
    input  logic [NUM_CH-1:0]                   md_ready,
    input  logic [NUM_CH-1:0]                   md_err,
    input  logic [NUM_CH*ALGN_DATA_WIDTH-1:0]   md_data,
    input  logic [NUM_CH*OFFSET_W-1:0]          md_offset,
    input  logic [NUM_CH*SIZE_W-1:0]            md_size,
    input  logic [TIMEOUT_W-1:0]                cfg_timeout,
    input  logic                                clr,
    output logic [NUM_CH-1:0]                   viol_drop,
    output logic [NUM_CH-1:0]                   viol_stable,
    output logic [NUM_CH-1:0]                   viol_err,
    output logic [NUM_CH-1:0]                   viol_align,
    output logic [NUM_CH-1:0]                   viol_timeout,
    output logic                                first_vld,
    output logic [CH_W-1:0]                     first_ch,
    output logic [2:0]                          first_code,
    output logic                                irq,
    output logic [NUM_CH*CNT_W-1:0]             xfer_cnt
);

    typedef enum logic {StIdle, StWait} state_e;

    // Bit index of each violation equals its reported code.
    logic [NUM_CH-1:0][4:0] viol_now;
    logic [NUM_CH-1:0][4:0] flag_all;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                       v, r, e;
        logic [ALGN_DATA_WIDTH-1:0] data, data_q, data_d;
        logic [OFFSET_W-1:0]        off, off_q, off_d;
        logic [SIZE_W-1:0]          size, size_q, size_d;
        logic [TIMEOUT_W-1:0]       stall_cnt_q, stall_cnt_d;
        logic                       fired_q, fired_d;
        state_e                     state_q, state_d;
        logic                       drop, stable, err, align, tmo;
        logic [SIZE_W:0]            end_pos;
        logic [4:0]                 flag_q;
        logic [CNT_W-1:0]           xcnt_q;

        assign v    = md_valid[c];
        assign r    = md_ready[c];
        assign e    = md_err[c];
        assign data = md_data[c*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
        assign off  = md_offset[c*OFFSET_W +: OFFSET_W];
        assign size = md_size[c*SIZE_W +: SIZE_W];

        always_comb begin
            state_d     = state_q;
            data_d      = data_q;
            off_d       = off_q;
            size_d      = size_q;
            stall_cnt_d = stall_cnt_q;
            fired_d     = fired_q;
            drop        = 1'b0;
            stable      = 1'b0;
            tmo         = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (v && !r) begin
                        data_d      = data;
                        off_d       = off;
                        size_d      = size;
                        stall_cnt_d = TIMEOUT_W'(1);
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    if (cfg_timeout != '0 && stall_cnt_q == cfg_timeout && !fired_q) begin
                        tmo     = 1'b1;
                        fired_d = 1'b1;
                    end
                    if (!v) begin
                        drop    = 1'b1;
                        state_d = StIdle;
                    end else if (data != data_q || off != off_q || size != size_q) begin
                        stable = 1'b1;
                    end else if (r) begin
                        state_d = StIdle;
                    end else if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                    if (state_d == StIdle) fired_d = 1'b0;
                end
            endcase
        end

        assign end_pos = (SIZE_W+1)'(off) + (SIZE_W+1)'(size);
        assign err     = e && !(v && r);
        assign align   = v && (size == '0 || end_pos > (SIZE_W+1)'(BUS_BYTES));
        assign viol_now[c] = {tmo, align, err, stable, drop};

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q     <= StIdle;
                data_q      <= '0;
                off_q       <= '0;
                size_q      <= '0;
                stall_cnt_q <= '0;
                fired_q     <= 1'b0;
                flag_q      <= '0;
                xcnt_q      <= '0;
            end else begin
                state_q     <= state_d;
                data_q      <= data_d;
                off_q       <= off_d;
                size_q      <= size_d;
                stall_cnt_q <= stall_cnt_d;
                fired_q     <= fired_d;
                flag_q      <= clr ? viol_now[c] : (flag_q | viol_now[c]);
                // A transfer coinciding with clr restarts the count at one.
                if (v && r) begin
                    if (clr)                 xcnt_q <= CNT_W'(1);
                    else if (xcnt_q != '1)   xcnt_q <= xcnt_q + 1'b1;
                end else if (clr) begin
                    xcnt_q <= '0;
                end
            end
        end

        assign flag_all[c]                    = flag_q;
        assign viol_drop[c]                   = flag_q[0];
        assign viol_stable[c]                 = flag_q[1];
        assign viol_err[c]                    = flag_q[2];
        assign viol_align[c]                  = flag_q[3];
        assign viol_timeout[c]                = flag_q[4];
        assign xfer_cnt[c*CNT_W +: CNT_W]     = xcnt_q;
    end

    logic            hit;
    logic [CH_W-1:0] hit_ch;
    logic [2:0]      hit_code;

    // Scan downwards so the lowest channel and lowest code overwrite last.
    always_comb begin
        hit      = 1'b0;
        hit_ch   = '0;
        hit_code = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (|viol_now[c]) begin
                hit    = 1'b1;
                hit_ch = CH_W'(c);
                for (int k = 4; k >= 0; k--) begin
                    if (viol_now[c][k]) hit_code = 3'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_code <= '0;
            irq        <= 1'b0;
        end else begin
            if ((clr || !first_vld) && hit) begin
                first_vld  <= 1'b1;
                first_ch   <= hit_ch;
                first_code <= hit_code;
            end else if (clr) begin
                first_vld  <= 1'b0;
                first_ch   <= '0;
                first_code <= '0;
            end
            irq <= |flag_all;
        end
    end

endmodule

// File: tb/tb_md_protocol_monitor.sv
// Directed self-checking bench for md_protocol_monitor (2 channels, 32-bit bus, 4-bit counters).
module tb_md_protocol_monitor;

    logic        clk;
    logic        reset_n;
    logic [1:0]  md_valid, md_ready, md_err;
    logic [63:0] md_data;
    logic [3:0]  md_offset;
    logic [5:0]  md_size;
    logic [7:0]  cfg_timeout;
    logic        clr;
    logic [1:0]  viol_drop, viol_stable, viol_err, viol_align, viol_timeout;
    logic        first_vld;
    logic [0:0]  first_ch;
    logic [2:0]  first_code;
    logic        irq;
    logic [7:0]  xfer_cnt;

    int total = 0;
    int bad   = 0;

    md_protocol_monitor #(
        .ALGN_DATA_WIDTH(32),
        .NUM_CH         (2),
        .TIMEOUT_W      (8),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_err      (md_err),
        .md_data     (md_data),
        .md_offset   (md_offset),
        .md_size     (md_size),
        .cfg_timeout (cfg_timeout),
        .clr         (clr),
        .viol_drop   (viol_drop),
        .viol_stable (viol_stable),
        .viol_err    (viol_err),
        .viol_align  (viol_align),
        .viol_timeout(viol_timeout),
        .first_vld   (first_vld),
        .first_ch    (first_ch),
        .first_code  (first_code),
        .irq         (irq),
        .xfer_cnt    (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic r, input logic e,
                          input logic [31:0] d, input logic [1:0] o, input logic [2:0] s);
        md_valid[c]        = v;
        md_ready[c]        = r;
        md_err[c]          = e;
        md_data[c*32 +: 32] = d;
        md_offset[c*2 +: 2] = o;
        md_size[c*3 +: 3]   = s;
    endtask

    task automatic idle_all();
        set_ch(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 3'd4);
        set_ch(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 3'd4);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clr = 1'b0;
        cfg_timeout = 8'd5;
        idle_all();
        #3;
        total++;
        if ({viol_drop, viol_stable, viol_err, viol_align, viol_timeout} !== 10'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0",
                     {viol_drop, viol_stable, viol_err, viol_align, viol_timeout});
        end
        total++;
        if ({first_vld, first_ch, first_code, irq} !== 6'b0) begin
            bad++;
            $display("FAIL reset_capture: got %b want 0", {first_vld, first_ch, first_code, irq});
        end
        total++;
        if (xfer_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_cnt: got %h want 00", xfer_cnt);
        end
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_stall_hold();
        cfg_timeout = 8'd5;
        set_ch(0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 2'd0, 3'd4);
        step();
        step();
        step();
        md_ready[0] = 1'b1;
        step();
        md_valid[0] = 1'b0;
        md_ready[0] = 1'b0;
        total++;
        if ({viol_drop, viol_stable, viol_err, viol_align, viol_timeout} !== 10'b0) begin
            bad++;
            $display("FAIL hold_flags: got %b want 0",
                     {viol_drop, viol_stable, viol_err, viol_align, viol_timeout});
        end
        total++;
        if (xfer_cnt[3:0] !== 4'd1) begin
            bad++;
            $display("FAIL hold_cnt: got %0d want 1", xfer_cnt[3:0]);
        end
        step();
        total++;
        if (irq !== 1'b0 || first_vld !== 1'b0) begin
            bad++;
            $display("FAIL hold_irq: got irq=%b vld=%b want 0 0", irq, first_vld);
        end
    endtask

    task automatic test_drop();
        set_ch(1, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 2'd0, 3'd4);
        step();
        step();
        md_valid[1] = 1'b0;
        step();
        total++;
        if (viol_drop !== 2'b10) begin
            bad++;
            $display("FAIL drop_flag: got %b want 10", viol_drop);
        end
        total++;
        if (first_vld !== 1'b1 || first_ch !== 1'b1 || first_code !== 3'd0) begin
            bad++;
            $display("FAIL drop_first: got vld=%b ch=%0d code=%0d want 1 1 0",
                     first_vld, first_ch, first_code);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL drop_irq_early: got %b want 0", irq);
        end
        step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL drop_irq: got %b want 1", irq);
        end
        do_clr();
    endtask

    task automatic test_stable_err();
        set_ch(0, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 2'd0, 3'd4);
        step();
        md_data[31:0] = 32'h5A5A_5A5A;
        md_err[1]     = 1'b1;
        step();
        total++;
        if (viol_stable !== 2'b01 || viol_err !== 2'b10 || viol_drop !== 2'b00) begin
            bad++;
            $display("FAIL stable_err_flags: got st=%b err=%b drop=%b want 01 10 00",
                     viol_stable, viol_err, viol_drop);
        end
        total++;
        if (first_ch !== 1'b0 || first_code !== 3'd1) begin
            bad++;
            $display("FAIL stable_first: got ch=%0d code=%0d want 0 1", first_ch, first_code);
        end
        md_data[31:0] = 32'hA5A5_A5A5;
        md_ready[0]   = 1'b1;
        md_err[1]     = 1'b0;
        step();
        md_valid[0] = 1'b0;
        md_ready[0] = 1'b0;
        step();
        total++;
        if (viol_drop !== 2'b00) begin
            bad++;
            $display("FAIL stable_recover: got drop=%b want 00", viol_drop);
        end
        do_clr();
    endtask

    task automatic test_align();
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h1, 2'd3, 3'd2);
        step();
        total++;
        if (viol_align !== 2'b01 || first_code !== 3'd3) begin
            bad++;
            $display("FAIL align_over: got %b code=%0d want 01 3", viol_align, first_code);
        end
        md_valid[0] = 1'b0;
        md_ready[0] = 1'b0;
        do_clr();
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h2, 2'd2, 3'd2);
        step();
        total++;
        if (viol_align !== 2'b00) begin
            bad++;
            $display("FAIL align_exact: got %b want 00", viol_align);
        end
        md_offset[1:0] = 2'd0;
        md_size[2:0]   = 3'd0;
        step();
        total++;
        if (viol_align !== 2'b01) begin
            bad++;
            $display("FAIL align_zero: got %b want 01", viol_align);
        end
        idle_all();
        do_clr();
    endtask

    task automatic test_timeout();
        logic exp;
        cfg_timeout = 8'd4;
        set_ch(0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 2'd0, 3'd4);
        step();
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) clr = 1'b1;
            if (i == 8) cfg_timeout = 8'd8;
            step();
            clr = 1'b0;
            exp = (i >= 4 && i < 6);
            total++;
            if (viol_timeout !== {1'b0, exp}) begin
                bad++;
                $display("FAIL timeout_cyc%0d: got %b want %b", i, viol_timeout, {1'b0, exp});
            end
            if (i == 4) begin
                total++;
                if (first_code !== 3'd4 || first_ch !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_first: got ch=%0d code=%0d want 0 4",
                             first_ch, first_code);
                end
            end
        end
        md_ready[0] = 1'b1;
        step();
        md_valid[0] = 1'b0;
        md_ready[0] = 1'b0;
        step();
        cfg_timeout = 8'd0;
        md_valid[0] = 1'b1;
        for (int i = 0; i < 11; i++) step();
        total++;
        if (viol_timeout !== 2'b00) begin
            bad++;
            $display("FAIL timeout_disabled: got %b want 00", viol_timeout);
        end
        md_ready[0] = 1'b1;
        step();
        idle_all();
        step();
        do_clr();
        cfg_timeout = 8'd5;
    endtask

    task automatic test_saturate();
        set_ch(0, 1'b1, 1'b1, 1'b0, 32'h77, 2'd0, 3'd4);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                total++;
                if (xfer_cnt[3:0] !== 4'd14) begin
                    bad++;
                    $display("FAIL cnt_14: got %0d want 14", xfer_cnt[3:0]);
                end
            end
        end
        total++;
        if (xfer_cnt !== 8'h0F) begin
            bad++;
            $display("FAIL cnt_sat: got %h want 0f", xfer_cnt);
        end
    endtask

    task automatic test_back_to_back_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (xfer_cnt[3:0] !== 4'd1) begin
            bad++;
            $display("FAIL clr_xfer: got %0d want 1", xfer_cnt[3:0]);
        end
        step();
        total++;
        if (xfer_cnt[3:0] !== 4'd2) begin
            bad++;
            $display("FAIL clr_xfer_next: got %0d want 2", xfer_cnt[3:0]);
        end
        idle_all();
        md_err[1] = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        md_err[1] = 1'b0;
        total++;
        if (viol_err !== 2'b10 || first_vld !== 1'b1 || first_ch !== 1'b1 ||
            first_code !== 3'd2 || xfer_cnt !== 8'h00) begin
            bad++;
            $display("FAIL clr_viol: got err=%b vld=%b ch=%0d code=%0d cnt=%h want 10 1 1 2 00",
                     viol_err, first_vld, first_ch, first_code, xfer_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid_stall();
        set_ch(0, 1'b1, 1'b0, 1'b0, 32'h3C3C_3C3C, 2'd0, 3'd4);
        md_ready[1] = 1'b1;
        md_valid[1] = 1'b1;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({viol_drop, viol_stable, viol_err, viol_align, viol_timeout, first_vld, irq} !== 12'b0
            || xfer_cnt !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got flags=%b vld=%b irq=%b cnt=%h want all 0",
                     {viol_drop, viol_stable, viol_err, viol_align, viol_timeout},
                     first_vld, irq, xfer_cnt);
        end
        idle_all();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (viol_drop !== 2'b00 || first_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_fsm_idle: got drop=%b vld=%b want 00 0", viol_drop, first_vld);
        end
    endtask

    initial begin
        test_reset();
        test_stall_hold();
        test_drop();
        test_stable_err();
        test_align();
        test_timeout();
        test_saturate();
        test_back_to_back_clr();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
